// File: rtl/bin2bcd_conv.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Optional overflow saturation to 9999_9999 is enabled by defining BIN2BCD_SAT_EN.
module bin2bcd_conv #(
  parameter int BIN_W = 27
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [31:0]      bcd_out
);

  localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W);
  localparam int WIDE_W = 36 + BIN_W;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [BIN_W-1:0] sh_reg;
  logic [35:0]      acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [35:0]       adj;
  logic [WIDE_W-1:0] wide_next;
  logic [35:0]       acc_next;
  logic [BIN_W-1:0]  sh_next;
  logic              ovf_next;
  logic [31:0]       bcd_next;

  // Add-3 correction on every digit before the shift.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                              (acc_reg[gi*4 +: 4] + 4'd3) : acc_reg[gi*4 +: 4];
    end
  endgenerate

  assign wide_next = {adj, sh_reg} << 1;
  assign acc_next  = wide_next[WIDE_W-1:BIN_W];
  assign sh_next   = wide_next[BIN_W-1:0];
  assign ovf_next  = |acc_next[35:32];

`ifdef BIN2BCD_SAT_EN
  assign bcd_next = ovf_next ? 32'h9999_9999 : acc_next[31:0];
`else
  assign bcd_next = acc_next[31:0];
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      bcd_out   <= 32'h0000_0000;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_reg    <= bin_in;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          sh_reg  <= sh_next;
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(BIN_W - 1)) begin
            bcd_out   <= bcd_next;
            ovf       <= ovf_next;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bin2bcd_conv.md
BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

Interface
REQ-001 The block SHALL have parameter BIN_W, default 27, giving the binary input width; legal range is 1..27.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: conversion request, sampled on each rising edge.
REQ-005 The block SHALL have port bin_in, input, BIN_W bits: unsigned binary value, sampled only when a start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that bcd_out has just been updated.
REQ-008 The block SHALL have port ovf, output, 1 bit: set when the latched value exceeds 99,999,999.
REQ-009 The block SHALL have port bcd_out, output, 32 bits: eight packed BCD digits; [3:0] holds the units digit and [31:28] holds the 10^7 digit, matching the display-driver nibble order.

Function
REQ-010 The block SHALL implement an iterative shift-add-3 (double-dabble) converter with states IDLE, SHIFT and DONE.
REQ-011 In IDLE, start=1 at edge k SHALL latch bin_in into the shift register, clear the 36-bit (9-digit) BCD accumulator and the iteration counter, and move the state to SHIFT.
REQ-012 In SHIFT, each edge SHALL first add 3 to every accumulator digit that is >=5, then shift {accumulator, shift register} left by one bit.
REQ-013 SHIFT SHALL run exactly BIN_W iterations; the edge that performs the last iteration SHALL move the state to DONE, update bcd_out and ovf, and set done=1.
REQ-014 Latency SHALL be BIN_W cycles from the accepting edge to the first cycle with done=1 (27 cycles at the default BIN_W).
REQ-015 DONE SHALL last exactly one cycle and then return to IDLE; done SHALL be high only in the DONE cycle.
REQ-016 busy SHALL be high exactly when the state is not IDLE, registered, i.e. from the accepting edge until the edge that leaves DONE.
REQ-017 start SHALL be ignored while busy=1, including during the DONE cycle; a later change of bin_in SHALL NOT affect a conversion already in flight.
REQ-018 bcd_out and ovf SHALL hold their values between done pulses and change only on the DONE-entry edge.
REQ-019 ovf SHALL be 1 when digit 8 (the 10^8 digit) of the accumulator is nonzero, and 0 otherwise.
REQ-020 Every nibble of bcd_out SHALL be in the range 0..9.
REQ-021 An input of 0 SHALL yield bcd_out=32'h0000_0000 with ovf=0.

Reset
REQ-022 While rst_n=0, independent of sys_clk: state=IDLE, busy=0, done=0, ovf=0, bcd_out=32'h0000_0000, and the iteration counter, shift register and accumulator are all zero.
REQ-023 A reset asserted mid-conversion SHALL abort it with no done pulse, and the outputs SHALL be at their reset values.
REQ-024 After rst_n is released, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-025 The macro BIN2BCD_SAT_EN SHALL control overflow saturation.
REQ-026 With BIN2BCD_SAT_EN defined and ovf=1, bcd_out SHALL be 32'h9999_9999.
REQ-027 Without BIN2BCD_SAT_EN and with ovf=1, bcd_out SHALL be the low eight digits of the result (value mod 10^8); ovf behaviour is identical in both builds.

Verification
REQ-028 Reset, then start with bin_in=12345678 -> busy rises at the start edge; done pulses 27 cycles later with bcd_out=32'h1234_5678 and ovf=0.
REQ-029 bin_in=99999999 -> bcd_out=32'h9999_9999, ovf=0; then bin_in=0 -> bcd_out=32'h0000_0000, ovf=0.
REQ-030 bin_in=134217727 -> ovf=1; bcd_out=32'h9999_9999 with BIN2BCD_SAT_EN defined, and 32'h3421_7727 without it.
REQ-031 Start bin_in=5, then pulse start with bin_in=7 at cycle 10 and again during the DONE cycle -> both extra starts are ignored, a single done pulse occurs with bcd_out=32'h0000_0005, and busy falls one cycle after done.
REQ-032 Assert rst_n=0 at cycle 15 of a conversion -> all outputs return to their reset values immediately, and no done pulse occurs after release.
REQ-033 Run 1000 random values in 0..134217727 against a reference model -> every bcd_out, ovf value and done timing matches.
